// File: rtl/bp_be_dcache_pkg.sv
// Shared types and default geometry for the dcache store write buffer.
// Entry struct widths follow the default dcache geometry below.
package bp_be_dcache_pkg;

    localparam int wbuf_data_width_gp         = 64;
    localparam int wbuf_paddr_width_gp        = 22;
    localparam int wbuf_ways_gp               = 8;
    localparam int wbuf_sets_gp               = 64;
    localparam int wbuf_block_offset_width_gp = 6;
    localparam int wbuf_els_gp                = 2;

    localparam int wbuf_way_id_width_gp = $clog2(wbuf_ways_gp);
    localparam int wbuf_mask_width_gp   = wbuf_data_width_gp / 8;

    typedef struct packed {
        logic [wbuf_paddr_width_gp-1:0]  paddr;
        logic [wbuf_way_id_width_gp-1:0] way_id;
        logic [wbuf_data_width_gp-1:0]   data;
        logic [wbuf_mask_width_gp-1:0]   mask;
    } bp_be_dcache_wbuf_entry_s;

endpackage

// File: rtl/bp_be_dcache_wbuf_queue.sv
// Two-entry shift-register store queue: el0 is always the oldest entry.
// Illegal enqueue/dequeue attempts leave all state untouched.
module bp_be_dcache_wbuf_queue
    import bp_be_dcache_pkg::*;
#(
    parameter int paddr_width_p  = wbuf_paddr_width_gp,
    parameter int way_id_width_p = wbuf_way_id_width_gp,
    parameter int data_width_p   = wbuf_data_width_gp,
    parameter int mask_width_p   = data_width_p / 8
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic                                  v_i,
    input  logic [paddr_width_p-1:0]              paddr_i,
    input  logic [way_id_width_p-1:0]             way_id_i,
    input  logic [data_width_p-1:0]               data_i,
    input  logic [mask_width_p-1:0]               mask_i,
    input  logic                                  yumi_i,
    output logic                                  ready_o,
    output logic                                  v_o,
    output logic                                  empty_o,
    output logic [wbuf_els_gp-1:0]                el_v_o,
    output logic [wbuf_els_gp-1:0][paddr_width_p-1:0] el_paddr_o,
    output logic [wbuf_els_gp-1:0][data_width_p-1:0]  el_data_o,
    output logic [wbuf_els_gp-1:0][mask_width_p-1:0]  el_mask_o,
    output logic [way_id_width_p-1:0]             head_way_id_o
);

    logic [1:0] count_reg, count_next;
    logic       illegal_enq, illegal_deq, hold, enq, deq;
    logic [1:0] enq_slot;

    logic [paddr_width_p-1:0]  paddr_reg  [wbuf_els_gp];
    logic [way_id_width_p-1:0] way_id_reg [wbuf_els_gp];
    logic [data_width_p-1:0]   data_reg   [wbuf_els_gp];
    logic [mask_width_p-1:0]   mask_reg   [wbuf_els_gp];
    logic [paddr_width_p-1:0]  paddr_next [wbuf_els_gp];
    logic [way_id_width_p-1:0] way_id_next[wbuf_els_gp];
    logic [data_width_p-1:0]   data_next  [wbuf_els_gp];
    logic [mask_width_p-1:0]   mask_next  [wbuf_els_gp];

    // Enqueue while full is legal only when the head retires the same cycle.
    assign illegal_enq = v_i & (count_reg == 2'd2) & ~yumi_i;
    assign illegal_deq = yumi_i & (count_reg == 2'd0);
    assign hold        = illegal_enq | illegal_deq;
    assign enq         = v_i & ~hold;
    assign deq         = yumi_i & ~hold;
    assign enq_slot    = count_reg - {1'b0, deq};
    assign count_next  = count_reg + {1'b0, enq} - {1'b0, deq};

    always_comb begin
        for (int i = 0; i < wbuf_els_gp; i++) begin
            paddr_next[i]  = paddr_reg[i];
            way_id_next[i] = way_id_reg[i];
            data_next[i]   = data_reg[i];
            mask_next[i]   = mask_reg[i];
            if (enq && (enq_slot == 2'(i))) begin
                paddr_next[i]  = paddr_i;
                way_id_next[i] = way_id_i;
                data_next[i]   = data_i;
                mask_next[i]   = mask_i;
            end else if (deq && (i == 0)) begin
                paddr_next[i]  = paddr_reg[1];
                way_id_next[i] = way_id_reg[1];
                data_next[i]   = data_reg[1];
                mask_next[i]   = mask_reg[1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_reg <= 2'd0;
            for (int i = 0; i < wbuf_els_gp; i++) begin
                paddr_reg[i]  <= '0;
                way_id_reg[i] <= '0;
                data_reg[i]   <= '0;
                mask_reg[i]   <= '0;
            end
        end else begin
            count_reg <= count_next;
            for (int i = 0; i < wbuf_els_gp; i++) begin
                paddr_reg[i]  <= paddr_next[i];
                way_id_reg[i] <= way_id_next[i];
                data_reg[i]   <= data_next[i];
                mask_reg[i]   <= mask_next[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!illegal_enq) else $warning("wbuf: enqueue while full dropped");
            assert (!illegal_deq) else $warning("wbuf: dequeue while empty dropped");
        end
    end

    assign ready_o       = (count_reg != 2'd2);
    assign v_o           = (count_reg != 2'd0);
    assign empty_o       = (count_reg == 2'd0);
    assign head_way_id_o = way_id_reg[0];
    assign el_v_o[0]     = (count_reg != 2'd0);
    assign el_v_o[1]     = (count_reg == 2'd2);

    for (genvar gi = 0; gi < wbuf_els_gp; gi++) begin : g_el_out
        assign el_paddr_o[gi] = paddr_reg[gi];
        assign el_data_o[gi]  = data_reg[gi];
        assign el_mask_o[gi]  = mask_reg[gi];
    end

endmodule

// File: rtl/bp_be_dcache_wbuf.sv
// Dcache store write buffer: queue plus byte-wise load bypass and LCE set snoop.
// Bypass and snoop are combinational from registered queue state only.
module bp_be_dcache_wbuf
    import bp_be_dcache_pkg::*;
#(
    parameter int data_width_p         = wbuf_data_width_gp,
    parameter int paddr_width_p        = wbuf_paddr_width_gp,
    parameter int ways_p               = wbuf_ways_gp,
    parameter int sets_p               = wbuf_sets_gp,
    parameter int block_offset_width_p = wbuf_block_offset_width_gp,
    localparam int way_id_width_lp     = $clog2(ways_p),
    localparam int mask_width_lp       = data_width_p / 8,
    localparam int index_width_lp      = $clog2(sets_p)
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        v_i,
    input  logic [paddr_width_p-1:0]    paddr_i,
    input  logic [way_id_width_lp-1:0]  way_id_i,
    input  logic [data_width_p-1:0]     data_i,
    input  logic [mask_width_lp-1:0]    mask_i,
    output logic                        ready_o,
    output logic                        v_o,
    output logic [paddr_width_p-1:0]    paddr_o,
    output logic [way_id_width_lp-1:0]  way_id_o,
    output logic [data_width_p-1:0]     data_o,
    output logic [mask_width_lp-1:0]    mask_o,
    input  logic                        yumi_i,
    input  logic                        bypass_v_i,
    input  logic [paddr_width_p-1:0]    bypass_paddr_i,
    output logic [data_width_p-1:0]     bypass_data_o,
    output logic [mask_width_lp-1:0]    bypass_mask_o,
    input  logic [index_width_lp-1:0]   lce_snoop_index_i,
    output logic                        lce_snoop_match_o,
    output logic                        empty_o
);

    localparam int byte_offset_lp = $clog2(mask_width_lp);

    logic [wbuf_els_gp-1:0]                     el_v;
    logic [wbuf_els_gp-1:0][paddr_width_p-1:0]  el_paddr;
    logic [wbuf_els_gp-1:0][data_width_p-1:0]   el_data;
    logic [wbuf_els_gp-1:0][mask_width_lp-1:0]  el_mask;
    logic [wbuf_els_gp-1:0]                     bypass_hit;
    logic [wbuf_els_gp-1:0]                     snoop_hit;
    logic                                       unused_bits;

    bp_be_dcache_wbuf_queue #(
        .paddr_width_p (paddr_width_p),
        .way_id_width_p(way_id_width_lp),
        .data_width_p  (data_width_p),
        .mask_width_p  (mask_width_lp)
    ) queue (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .v_i          (v_i),
        .paddr_i      (paddr_i),
        .way_id_i     (way_id_i),
        .data_i       (data_i),
        .mask_i       (mask_i),
        .yumi_i       (yumi_i),
        .ready_o      (ready_o),
        .v_o          (v_o),
        .empty_o      (empty_o),
        .el_v_o       (el_v),
        .el_paddr_o   (el_paddr),
        .el_data_o    (el_data),
        .el_mask_o    (el_mask),
        .head_way_id_o(way_id_o)
    );

    assign paddr_o = el_paddr[0];
    assign data_o  = el_data[0];
    assign mask_o  = el_mask[0];

    // Loads match on the doubleword address; byte offset selects lanes only.
    for (genvar gi = 0; gi < wbuf_els_gp; gi++) begin : g_el_cmp
        assign bypass_hit[gi] = bypass_v_i & el_v[gi]
            & (el_paddr[gi][paddr_width_p-1:byte_offset_lp]
               == bypass_paddr_i[paddr_width_p-1:byte_offset_lp]);
        assign snoop_hit[gi] = el_v[gi]
            & (el_paddr[gi][block_offset_width_p+:index_width_lp] == lce_snoop_index_i);
    end

    // el1 is the younger store, so its bytes take priority over el0.
    for (genvar gi = 0; gi < mask_width_lp; gi++) begin : g_byte
        logic take1, take0;
        assign take1 = bypass_hit[1] & el_mask[1][gi];
        assign take0 = bypass_hit[0] & el_mask[0][gi];
        assign bypass_mask_o[gi] = take1 | take0;
        assign bypass_data_o[8*gi+:8] = take1 ? el_data[1][8*gi+:8]
                                      : take0 ? el_data[0][8*gi+:8]
                                      : 8'h00;
    end

    assign lce_snoop_match_o = |snoop_hit;

    assign unused_bits = ^{bypass_paddr_i[byte_offset_lp-1:0], el_paddr[1][byte_offset_lp-1:0]};

endmodule
